// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, ALU function
// selects, sequencer state encoding, instruction field positions, control word.
package cpu_pkg;

  localparam int NBIT = 16;
  localparam int PC_W = 6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FS_ADD = 3'd0;
  localparam logic [2:0] FS_SUB = 3'd1;
  localparam logic [2:0] FS_AND = 3'd2;
  localparam logic [2:0] FS_OR  = 3'd3;
  localparam logic [2:0] FS_XOR = 3'd4;
  localparam logic [2:0] FS_NOT = 3'd5;
  localparam logic [2:0] FS_SHL = 3'd6;
  localparam logic [2:0] FS_SHR = 3'd7;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int DA_MSB   = 11;
  localparam int DA_LSB   = 8;
  localparam int AA_MSB   = 7;
  localparam int AA_LSB   = 4;
  localparam int BA_MSB   = 3;
  localparam int BA_LSB   = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;
  localparam int TGT_MSB  = 5;
  localparam int TGT_LSB  = 0;

  typedef struct packed {
    logic [2:0] fs;
    logic       mb;
    logic       md;
    logic       mj;
    logic       mm;
    logic       mk;
    logic       a_thru;
    logic       b_thru;
    logic       is_ld;
    logic       is_st;
    logic       is_branch;
    logic       is_jump;
    logic       is_jal;
    logic       is_halt;
    logic       writes_rd;
  } ctrl_t;

  // ALU opcodes 1..8 map onto function selects 0..7.
  function automatic logic [2:0] alu_fs(input logic [3:0] op);
    logic [3:0] t;
    t = op - 4'd1;
    return t[2:0];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: produces the static part of the datapath
// control word; every bit not used by an opcode stays 0.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        ctrl_o.fs        = alu_fs(op_i);
        ctrl_o.writes_rd = 1'b1;
      end
      OP_LDI: begin
        ctrl_o.mb        = 1'b1;
        ctrl_o.b_thru    = 1'b1;
        ctrl_o.writes_rd = 1'b1;
      end
      OP_LD: begin
        ctrl_o.a_thru = 1'b1;
        ctrl_o.md     = 1'b1;
        ctrl_o.is_ld  = 1'b1;
      end
      OP_ST:  ctrl_o.is_st = 1'b1;
      OP_BZ: begin
        ctrl_o.mk        = 1'b1;
        ctrl_o.a_thru    = 1'b1;
        ctrl_o.is_branch = 1'b1;
      end
      OP_JMP: ctrl_o.is_jump = 1'b1;
      OP_JAL: begin
        // MM stays 0 so the jump target comes from R[AA] via MUX_M.
        ctrl_o.mj        = 1'b1;
        ctrl_o.is_jal    = 1'b1;
        ctrl_o.writes_rd = 1'b1;
      end
      OP_HALT: ctrl_o.is_halt = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/HALT) holding PC and IR.
// Memory handshake: mem_re/mem_we is held with a stable control word until
// the cycle mem_ready=1; the transfer completes at that clock edge.
module control_unit #(
  parameter int nBit = 16,
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [nBit-1:0] instr,
  input  logic            zero_flag,
  input  logic [PC_W-1:0] MUX_M,
  input  logic            mem_ready,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_prev,
  output logic [3:0]      DA,
  output logic [3:0]      AA,
  output logic [3:0]      BA,
  output logic [2:0]      FS,
  output logic            RW,
  output logic            MB,
  output logic            MD,
  output logic            MJ,
  output logic            MM,
  output logic            MK,
  output logic            A_thru,
  output logic            B_thru,
  output logic            mem_re,
  output logic            mem_we,
  output logic            halted,
  output logic [2:0]      state_o
);
  import cpu_pkg::*;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [nBit-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;
  ctrl_t           ctrl;

  instr_decoder u_dec (
    .op_i   (ir_q[OP_MSB:OP_LSB]),
    .ctrl_o (ctrl)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign tgt    = PC_W'(ir_q[TGT_MSB:TGT_LSB]);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    RW      = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (ctrl.is_ld) begin
          mem_re  = 1'b1;
          state_d = ST_MEM;
        end else if (ctrl.is_st) begin
          mem_we  = 1'b1;
          state_d = ST_MEM;
        end else if (ctrl.is_halt) begin
          state_d = ST_HALT;
        end else begin
          RW      = ctrl.writes_rd;
          state_d = ST_FETCH;
          // JAL samples MUX_M in the same cycle the link is written, so a
          // link into the target register still jumps to the old value.
          if (ctrl.is_jal)
            pc_d = MUX_M;
          else if (ctrl.is_jump || (ctrl.is_branch && zero_flag))
            pc_d = tgt;
          else
            pc_d = pc_inc;
        end
      end
      ST_MEM: begin
        mem_re = ctrl.is_ld;
        mem_we = ctrl.is_st;
        if (mem_ready) begin
          RW      = ctrl.is_ld;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign PC      = pc_q;
  assign PC_prev = pc_inc;
  assign DA      = ir_q[DA_MSB:DA_LSB];
  assign AA      = ir_q[AA_MSB:AA_LSB];
  assign BA      = ir_q[BA_MSB:BA_LSB];
  assign FS      = ctrl.fs;
  assign MB      = ctrl.mb;
  assign MD      = ctrl.md;
  assign MJ      = ctrl.mj;
  assign MM      = ctrl.mm;
  assign MK      = ctrl.mk;
  assign A_thru  = ctrl.a_thru;
  assign B_thru  = ctrl.b_thru;
  assign halted  = (state_q == ST_HALT);
  assign state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected trace of
// {state, PC, RW, mem_re, mem_we, halted} held in a queue and popped each cycle.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        zero_flag;
  logic [5:0]  MUX_M;
  logic        mem_ready;
  logic [5:0]  PC, PC_prev;
  logic [3:0]  DA, AA, BA;
  logic [2:0]  FS;
  logic        RW, MB, MD, MJ, MM, MK, A_thru, B_thru;
  logic        mem_re, mem_we, halted;
  logic [2:0]  state_o;

  logic [15:0] imem [64];
  logic [12:0] exp_q[$];
  logic [7:0]  stim_q[$];
  int          n_checks;
  int          n_fail;

  control_unit #(.nBit(16), .PC_W(6)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag),
    .MUX_M(MUX_M), .mem_ready(mem_ready), .PC(PC), .PC_prev(PC_prev),
    .DA(DA), .AA(AA), .BA(BA), .FS(FS), .RW(RW), .MB(MB), .MD(MD),
    .MJ(MJ), .MM(MM), .MK(MK), .A_thru(A_thru), .B_thru(B_thru),
    .mem_re(mem_re), .mem_we(mem_we), .halted(halted), .state_o(state_o)
  );

  // clock / instruction memory
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign instr = imem[PC];

  function automatic logic [12:0] obs();
    return {state_o, PC, RW, mem_re, mem_we, halted};
  endfunction

  function automatic logic [12:0] sig(input logic [2:0] st, input logic [5:0] pc,
                                      input logic rw, input logic re,
                                      input logic we, input logic h);
    return {st, pc, rw, re, we, h};
  endfunction

  function automatic logic [7:0] stim(input logic rdy, input logic zf, input logic [5:0] mm);
    return {rdy, zf, mm};
  endfunction

  // driver tasks
  task automatic load_nops();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    MUX_M = 6'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_cycle();
    logic [7:0] s;
    @(negedge clk);
    s = (stim_q.size() > 0) ? stim_q.pop_front() : 8'h00;
    {mem_ready, zero_flag, MUX_M} = s;
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    int k;
    load_nops();
    imem[0] = 16'hA310;
    do_reset();
    exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd0, 0, 1, 0, 0));
    repeat (2) exp_q.push_back(sig(ST_MEM, 6'd0, 0, 1, 0, 0));
    k = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_trace[%0d]: got %h expected %h", k, obs(), e);
      end
      if (k == 0) begin
        n_checks++;
        if ({FS, MB, MD, MJ, MM, MK, A_thru, B_thru} !== 10'd0) begin
          n_fail++;
          $display("FAIL reset_ctrl: got %b expected 0", {FS, MB, MD, MJ, MM, MK, A_thru, B_thru});
        end
      end
      k++;
    end
    do_reset();
    drive_cycle();
    n_checks++;
    if ({state_o, PC, mem_re, RW, halted} !== {ST_FETCH, 6'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got st=%0d pc=%0d re=%b rw=%b expected st=0 pc=0 re=0 rw=0",
               state_o, PC, mem_re, RW);
    end
  endtask

  task automatic test_ldi_add();
    logic [12:0] e;
    int k;
    load_nops();
    imem[0] = 16'h9105;
    imem[1] = 16'h1211;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(sig(ST_FETCH, 6'(i), 0, 0, 0, 0));
      exp_q.push_back(sig(ST_DECODE, 6'(i), 0, 0, 0, 0));
      exp_q.push_back(sig(ST_EXEC, 6'(i), 1, 0, 0, 0));
    end
    exp_q.push_back(sig(ST_FETCH, 6'd2, 0, 0, 0, 0));
    k = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL ldi_add_trace[%0d]: got %h expected %h", k, obs(), e);
      end
      if (k == 2) begin
        n_checks++;
        if ({MB, B_thru, MD, A_thru, DA} !== {4'b1100, 4'd1}) begin
          n_fail++;
          $display("FAIL ldi_ctrl: got mb=%b bt=%b md=%b at=%b da=%0d expected 1 1 0 0 1",
                   MB, B_thru, MD, A_thru, DA);
        end
      end
      if (k == 5) begin
        n_checks++;
        if ({FS, MB, DA, AA, BA} !== {3'b000, 1'b0, 12'h211}) begin
          n_fail++;
          $display("FAIL add_ctrl: got fs=%b mb=%b da=%0d aa=%0d ba=%0d expected 000 0 2 1 1",
                   FS, MB, DA, AA, BA);
        end
      end
      k++;
    end
  endtask

  task automatic test_alu_fs();
    logic [12:0] e;
    logic [11:0] fields;
    logic [3:0]  op;
    logic [2:0]  exp_fs;
    for (int o = 1; o <= 8; o++) begin
      load_nops();
      op = 4'(o);
      fields = 12'($urandom_range(0, 4095));
      imem[0] = {op, fields};
      exp_fs = 3'(o - 1);
      do_reset();
      exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_EXEC, 6'd0, 1, 0, 0, 0));
      exp_q.push_back(sig(ST_FETCH, 6'd1, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL alu_trace op=%0d: got %h expected %h", o, obs(), e);
        end
        if (state_o == ST_EXEC) begin
          n_checks++;
          if ({FS, DA, AA, BA, MB, MD, MJ, MK, A_thru, B_thru} !== {exp_fs, fields, 6'd0}) begin
            n_fail++;
            $display("FAIL alu_ctrl op=%0d: got fs=%b fields=%h expected fs=%b fields=%h",
                     o, FS, {DA, AA, BA}, exp_fs, fields);
          end
        end
      end
    end
  endtask

  task automatic test_ld_wait();
    logic [12:0] e;
    int re_cycles;
    load_nops();
    imem[0] = 16'hA310;
    do_reset();
    repeat (3) stim_q.push_back(stim(0, 0, 6'd0));
    repeat (3) stim_q.push_back(stim(0, 0, 6'd0));
    stim_q.push_back(stim(1, 0, 6'd0));
    stim_q.push_back(stim(0, 0, 6'd0));
    exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd0, 0, 1, 0, 0));
    repeat (3) exp_q.push_back(sig(ST_MEM, 6'd0, 0, 1, 0, 0));
    exp_q.push_back(sig(ST_MEM, 6'd0, 1, 1, 0, 0));
    exp_q.push_back(sig(ST_FETCH, 6'd1, 0, 0, 0, 0));
    re_cycles = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      if (mem_re) re_cycles++;
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL ld_trace: got %h expected %h", obs(), e);
      end
      if (mem_ready && state_o == ST_MEM) begin
        n_checks++;
        if ({MD, A_thru, DA} !== {2'b11, 4'd3}) begin
          n_fail++;
          $display("FAIL ld_ready_ctrl: got md=%b at=%b da=%0d expected 1 1 3", MD, A_thru, DA);
        end
      end
    end
    n_checks++;
    if (re_cycles != 5) begin
      n_fail++;
      $display("FAIL ld_re_len: got %0d expected 5", re_cycles);
    end
  endtask

  task automatic test_st();
    logic [12:0] e;
    load_nops();
    imem[0] = 16'hB012;
    do_reset();
    repeat (5) stim_q.push_back(stim(1, 0, 6'd0));
    exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd0, 0, 0, 1, 0));
    exp_q.push_back(sig(ST_MEM, 6'd0, 0, 0, 1, 0));
    exp_q.push_back(sig(ST_FETCH, 6'd1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL st_trace: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_bz();
    logic [12:0] e;
    logic [5:0]  exp_pc;
    for (int zf = 1; zf >= 0; zf--) begin
      load_nops();
      imem[0] = 16'hC02A;
      exp_pc = (zf == 1) ? 6'h2A : 6'h01;
      do_reset();
      repeat (4) stim_q.push_back(stim(0, 1'(zf), 6'd0));
      exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_EXEC, 6'd0, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_FETCH, exp_pc, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL bz_trace zf=%0d: got %h expected %h", zf, obs(), e);
        end
        if (state_o == ST_EXEC) begin
          n_checks++;
          if ({MK, A_thru, MJ, MB, FS} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL bz_ctrl: got mk=%b at=%b mj=%b mb=%b fs=%b expected 1 1 0 0 000",
                     MK, A_thru, MJ, MB, FS);
          end
        end
      end
    end
  endtask

  task automatic test_jal_wrap();
    logic [12:0] e;
    load_nops();
    imem[0]  = 16'hD03F;
    imem[63] = 16'hE410;
    do_reset();
    repeat (7) stim_q.push_back(stim(0, 0, 6'h10));
    exp_q.push_back(sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd0, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_FETCH, 6'd63, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd63, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd63, 1, 0, 0, 0));
    exp_q.push_back(sig(ST_FETCH, 6'h10, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL jal_trace: got %h expected %h", obs(), e);
      end
      if (state_o == ST_EXEC && PC == 6'd63) begin
        n_checks++;
        if ({MJ, MM, PC_prev, DA, AA} !== {2'b10, 6'd0, 4'd4, 4'd1}) begin
          n_fail++;
          $display("FAIL jal_ctrl: got mj=%b mm=%b pc_prev=%0d da=%0d aa=%0d expected 1 0 0 4 1",
                   MJ, MM, PC_prev, DA, AA);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [12:0] e;
    load_nops();
    imem[5] = 16'hF000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(sig(ST_FETCH, 6'(i), 0, 0, 0, 0));
      exp_q.push_back(sig(ST_DECODE, 6'(i), 0, 0, 0, 0));
      exp_q.push_back(sig(ST_EXEC, 6'(i), 0, 0, 0, 0));
    end
    exp_q.push_back(sig(ST_FETCH, 6'd5, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_DECODE, 6'd5, 0, 0, 0, 0));
    exp_q.push_back(sig(ST_EXEC, 6'd5, 0, 0, 0, 0));
    repeat (12) exp_q.push_back(sig(ST_HALT, 6'd5, 0, 0, 0, 1));
    repeat (30) stim_q.push_back(stim(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'h2A));
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL halt_trace: got %h expected %h", obs(), e);
      end
    end
    do_reset();
    drive_cycle();
    n_checks++;
    if (obs() !== sig(ST_FETCH, 6'd0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL halt_reset: got %h expected %h", obs(), sig(ST_FETCH, 6'd0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic [15:0] ins;
    logic [11:0] fields;
    logic [3:0]  op;
    logic [5:0]  pc;
    logic        zf;
    int          sel;
    load_nops();
    for (int i = 0; i < 64; i++) begin
      sel = $urandom_range(0, 11);
      op = (sel <= 9) ? 4'(sel) : ((sel == 10) ? OP_BZ : OP_JMP);
      fields = 12'($urandom_range(0, 4095));
      imem[i] = {op, fields};
    end
    do_reset();
    pc = 6'd0;
    for (int n = 0; n < 30; n++) begin
      ins = imem[pc];
      op = ins[15:12];
      zf = 1'($urandom_range(0, 1));
      repeat (3) stim_q.push_back(stim(0, zf, 6'($urandom_range(0, 63))));
      exp_q.push_back(sig(ST_FETCH, pc, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_DECODE, pc, 0, 0, 0, 0));
      exp_q.push_back(sig(ST_EXEC, pc, (op >= 4'd1 && op <= 4'd9), 0, 0, 0));
      if (op == OP_JMP || (op == OP_BZ && zf)) pc = ins[5:0];
      else pc = pc + 6'd1;
    end
    exp_q.push_back(sig(ST_FETCH, pc, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL b2b_trace: got %h expected %h", obs(), e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    MUX_M = 6'd0;
    test_reset();
    test_ldi_add();
    test_alu_fs();
    test_ld_wait();
    test_st();
    test_bz();
    test_jal_wrap();
    test_halt();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
